// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, default payload width and parity polarity
// used by both the TX framer and the RX parity check.
package uart_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Parity generator for the TX framer; holds the bit computed from the accepted byte
// so the frame in flight keeps its own parity.
module uart_tx_parity_calc
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  accept,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    logic par_c;

    // Even parity makes the total count of ones even; odd inverts it.
    assign par_c = (par_typ == PAR_ODD) ? ~(^data) : ^data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bit <= 1'b0;
        end else if (accept) begin
            par_bit <= par_c;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer, one clk per bit: start, LSB-first data, optional parity, stop.
// Define UART_TX_TWO_STOP_EN to emit two stop bits per frame.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    tx_state_e             state_q, state_n;
    logic [CNT_W-1:0]      cnt_q, cnt_n;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_bit;
    logic                  tx_n, busy_n;
    logic                  accept_c;

    uart_tx_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .clk     (clk),
        .rst     (rst),
        .accept  (accept_c),
        .data    (P_DATA),
        .par_typ (PAR_TYP),
        .par_bit (par_bit)
    );

    // Next state and next line value; outputs are the registered form of these.
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        tx_n     = 1'b1;
        busy_n   = 1'b1;
        accept_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_n = 1'b0;
                if (DATA_VALID) begin
                    accept_c = 1'b1;
                    state_n  = S_START;
                    tx_n     = 1'b0;
                    busy_n   = 1'b1;
                end
            end
            S_START: begin
                state_n = S_DATA;
                tx_n    = data_q[0];
            end
            S_DATA: begin
                if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                    cnt_n = '0;
                    if (par_en_q) begin
                        state_n = S_PARITY;
                        tx_n    = par_bit;
                    end else begin
                        state_n = S_STOP;
                    end
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                    tx_n  = data_q[cnt_n];
                end
            end
            S_PARITY: begin
                state_n = S_STOP;
            end
            S_STOP: begin
`ifdef UART_TX_TWO_STOP_EN
                // Counter is free here; it marks the first of the two stop bits.
                if (cnt_q == '0) begin
                    cnt_n = CNT_W'(1);
                end else begin
                    cnt_n   = '0;
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
                end
`else
                state_n = S_IDLE;
                busy_n  = 1'b0;
`endif
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            par_en_q <= 1'b0;
            TX_OUT   <= 1'b1;
            Busy     <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            TX_OUT  <= tx_n;
            Busy    <= busy_n;
            if (accept_c) begin
                data_q   <= P_DATA;
                par_en_q <= PAR_EN;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: a line model queues the expected (TX_OUT, Busy)
// pair for every cycle of each accepted frame and checks it cycle by cycle.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       Busy;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    logic [1:0] exp_q[$];
    logic       exp_busy_prev = 1'b0;

    uart_tx_frame dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    // Expected line activity for one frame, pairs are {TX_OUT, Busy}.
    task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt);
        logic pbit;
        exp_q.push_back(2'b01);
        for (int i = 0; i < 8; i++) exp_q.push_back({d[i], 1'b1});
        pbit = pt ? ~(^d) : ^d;
        if (pe) exp_q.push_back({pbit, 1'b1});
        exp_q.push_back(2'b11);
`ifdef UART_TX_TWO_STOP_EN
        exp_q.push_back(2'b11);
`endif
    endtask

    task automatic check(input string tag);
        logic [1:0] exp;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b10;
        vectors++;
        assert ({TX_OUT, Busy} === exp) else begin
            miscompares++;
            $error("FAIL %s: tx_out/busy got %b/%b expected %b/%b", tag, TX_OUT, Busy, exp[1], exp[0]);
        end
        exp_busy_prev = exp[0];
    endtask

    // Drive one cycle of inputs from the falling edge, then check at the next falling edge.
    task automatic step(input logic v, input logic [7:0] d, input logic pe, input logic pt,
                        input string tag);
        DATA_VALID = v;
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        @(posedge clk);
        if (rst && v && !exp_busy_prev) push_frame(d, pe, pt);
        @(negedge clk);
        check(tag);
    endtask

    task automatic idle_steps(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, tag);
    endtask

    initial begin
        rst        = 1'b0;
        P_DATA     = 8'h00;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        @(negedge clk);

        // Reset held with DATA_VALID toggling: line stays idle.
        step(1'b1, 8'hA5, 1'b0, 1'b0, "rst_hold0");
        step(1'b0, 8'hA5, 1'b0, 1'b0, "rst_hold1");
        step(1'b1, 8'hA5, 1'b0, 1'b0, "rst_hold2");
        rst = 1'b1;
        idle_steps(2, "idle_after_rst");

        // 0xA5, no parity, single-cycle request.
        step(1'b1, 8'hA5, 1'b0, 1'b0, "a5_nopar");
        idle_steps(12, "a5_nopar");

        // 0xA5 with even then odd parity.
        step(1'b1, 8'hA5, 1'b1, 1'b0, "a5_even");
        idle_steps(13, "a5_even");
        step(1'b1, 8'hA5, 1'b1, 1'b1, "a5_odd");
        idle_steps(13, "a5_odd");

        // 0x00 odd parity; payload and config change mid-frame must not leak in.
        step(1'b1, 8'h00, 1'b1, 1'b1, "zero_odd");
        for (int i = 0; i < 5; i++) step(1'b0, 8'hFF, 1'b0, 1'b0, "zero_odd_mid");
        idle_steps(8, "zero_odd");

        // Held request: 0x3C then 0xC3 with one idle gap; extra pulses during Busy ignored.
        step(1'b1, 8'h3C, 1'b0, 1'b0, "b2b_first");
        for (int i = 0; i < 9; i++) step(1'b1, 8'hC3, 1'b0, 1'b0, "b2b_hold");
        step(1'b1, 8'hC3, 1'b0, 1'b0, "b2b_gap");
        step(1'b1, 8'hC3, 1'b0, 1'b0, "b2b_second");
        DATA_VALID = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b0, "b2b_tail");
        step(1'b1, 8'h99, 1'b1, 1'b0, "pulse_in_busy");
        idle_steps(8, "b2b_tail");

        // Asynchronous reset while data bit 4 is on the line.
        step(1'b1, 8'h0F, 1'b0, 1'b0, "abort_frame");
        for (int i = 0; i < 5; i++) step(1'b0, 8'h0F, 1'b0, 1'b0, "abort_bits");
        #2;
        rst = 1'b0;
        #1;
        exp_q.delete();
        check("async_rst");
        @(negedge clk);
        step(1'b1, 8'h55, 1'b0, 1'b0, "abort_hold");
        rst = 1'b1;
        idle_steps(1, "abort_release");
        step(1'b1, 8'h55, 1'b0, 1'b0, "frame_55");
        idle_steps(12, "frame_55");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
